// File: rtl/coder_4_2_serial_pkg.sv
// Shared widths, types and decode helper for coder_4_2_serial.
package coder_4_2_serial_pkg;
  localparam int INDEX_W = 2;
  localparam int CODE_W  = 4;

  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [CODE_W-1:0]  code_t;

  localparam code_t RESULT_RST = 4'b0000;

  function automatic code_t onehot(input index_t idx);
    code_t r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/coder_4_2_serial_if.sv
// Request/result bundle for coder_4_2_serial; encoder signals present only
// when CODER_4_2_SERIAL_ENCODE_EN is defined.
interface coder_4_2_serial_if;
  import coder_4_2_serial_pkg::*;

  logic   en;
  index_t index;
  code_t  result;
  logic   valid;
`ifdef CODER_4_2_SERIAL_ENCODE_EN
  code_t  code;
  index_t enc_index;
  logic   enc_hit;
  logic   enc_multi;
`endif

`ifdef CODER_4_2_SERIAL_ENCODE_EN
  modport master (output en, index, code, input result, valid, enc_index, enc_hit, enc_multi);
  modport slave  (input en, index, code, output result, valid, enc_index, enc_hit, enc_multi);
`else
  modport master (output en, index, input result, valid);
  modport slave  (input en, index, output result, valid);
`endif
endinterface

// File: rtl/coder_4_2_serial_prienc.sv
// Combinational 4-to-2 priority encoder, highest set bit wins, with hit/multi flags.
module coder_4_2_serial_prienc
  import coder_4_2_serial_pkg::*;
(
  input  code_t  code,
  output index_t enc_index,
  output logic   enc_hit,
  output logic   enc_multi
);
  logic [2:0] ones;

  always_comb begin
    enc_index = '0;
    ones      = '0;
    // Ascending scan so the last (highest) set bit overwrites lower ones.
    for (int unsigned i = 0; i < CODE_W; i++) begin
      if (code[i]) begin
        enc_index = index_t'(i);
        ones      = ones + 3'd1;
      end
    end
    enc_hit   = (ones != 3'd0);
    enc_multi = (ones > 3'd1);
  end
endmodule

// File: rtl/coder_4_2_serial.sv
// Registered 2-to-4 one-hot decoder; optional registered priority encoder
// enabled by CODER_4_2_SERIAL_ENCODE_EN.
module coder_4_2_serial
  import coder_4_2_serial_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  coder_4_2_serial_if.slave  bus
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.result <= RESULT_RST;
      bus.valid  <= 1'b0;
    end else begin
      bus.valid  <= bus.en;
      bus.result <= bus.en ? onehot(bus.index) : RESULT_RST;
    end
  end

`ifdef CODER_4_2_SERIAL_ENCODE_EN
  index_t enc_index_c;
  logic   enc_hit_c;
  logic   enc_multi_c;

  coder_4_2_serial_prienc u_prienc (
    .code      (bus.code),
    .enc_index (enc_index_c),
    .enc_hit   (enc_hit_c),
    .enc_multi (enc_multi_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.enc_index <= '0;
      bus.enc_hit   <= 1'b0;
      bus.enc_multi <= 1'b0;
    end else begin
      bus.enc_index <= enc_index_c;
      bus.enc_hit   <= enc_hit_c;
      bus.enc_multi <= enc_multi_c;
    end
  end
`endif
endmodule

// File: tb/tb_coder_4_2_serial.sv
// Directed scoreboard bench for coder_4_2_serial (both macro builds).
module tb_coder_4_2_serial;
  import coder_4_2_serial_pkg::*;

  typedef struct {
    logic [3:0] result;
    logic       valid;
    logic [1:0] enc_index;
    logic       enc_hit;
    logic       enc_multi;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [3:0] tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  coder_4_2_serial_if bus ();

  coder_4_2_serial dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Drives one cycle at the negedge, pushes the expectation, checks after the edge.
  // model_code is what the encoder expectation is computed from.
  task automatic step(input logic rst, input logic e, input logic [1:0] idx,
                      input logic [3:0] cd, input logic [3:0] model_code);
    exp_t x;
    exp_t got;
    int   n;
    @(negedge clk);
    reset     = rst;
    bus.en    = e;
    bus.index = idx;
`ifdef CODER_4_2_SERIAL_ENCODE_EN
    bus.code  = cd;
`endif
    x.result    = (rst && e) ? tbl[idx] : 4'b0000;
    x.valid     = rst && e;
    x.enc_index = 2'd0;
    n = 0;
    for (int i = 0; i < 4; i++)
      if (model_code[i]) begin
        x.enc_index = 2'(i);
        n++;
      end
    x.enc_hit   = rst && (n > 0);
    x.enc_multi = rst && (n > 1);
    if (!rst) x.enc_index = 2'd0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    assert (bus.result === got.result) else begin
      errors++;
      $error("FAIL result: actual=%b required=%b", bus.result, got.result);
    end
    checks++;
    assert (bus.valid === got.valid) else begin
      errors++;
      $error("FAIL valid: actual=%b required=%b", bus.valid, got.valid);
    end
`ifdef CODER_4_2_SERIAL_ENCODE_EN
    checks++;
    assert (bus.enc_index === got.enc_index) else begin
      errors++;
      $error("FAIL enc_index: actual=%0d required=%0d", bus.enc_index, got.enc_index);
    end
    checks++;
    assert (bus.enc_hit === got.enc_hit) else begin
      errors++;
      $error("FAIL enc_hit: actual=%b required=%b", bus.enc_hit, got.enc_hit);
    end
    checks++;
    assert (bus.enc_multi === got.enc_multi) else begin
      errors++;
      $error("FAIL enc_multi: actual=%b required=%b", bus.enc_multi, got.enc_multi);
    end
`endif
  endtask

  initial begin
    logic [1:0] prev_idx;
    reset     = 1'b0;
    bus.en    = 1'b1;
    bus.index = 2'd2;
`ifdef CODER_4_2_SERIAL_ENCODE_EN
    bus.code  = 4'b0000;
`endif

    // Reset held two cycles while a request is presented.
    step(1'b0, 1'b1, 2'd2, 4'b1111, 4'b1111);
    step(1'b0, 1'b1, 2'd2, 4'b1111, 4'b1111);

    // Back-to-back sweep including 3 -> 0 wrap.
    step(1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 2'd1, 4'b0100, 4'b0100);
    step(1'b1, 1'b1, 2'd2, 4'b0110, 4'b0110);
    step(1'b1, 1'b1, 2'd3, 4'b1111, 4'b1111);
    step(1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001);

    // en toggling with index 3: no stale hold.
    step(1'b1, 1'b1, 2'd3, 4'b1000, 4'b1000);
    step(1'b1, 1'b0, 2'd3, 4'b0011, 4'b0011);
    step(1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000);

    // Reset mid-sweep at index 2, then resume.
    step(1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 2'd1, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 2'd2, 4'b0110, 4'b0110);
    step(1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000);

`ifdef CODER_4_2_SERIAL_ENCODE_EN
    // Loop-back: drive code from the DUT result; expectation from index history.
    prev_idx = 2'd0;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] idx;
      idx = 2'(k + 1);
      step(1'b1, 1'b1, idx, bus.result, tbl[prev_idx]);
      prev_idx = idx;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
